xreg_bank: RTL and testbench
============================

// Module: xreg_bank
// PURPOSE
//  Parametrised index-register bank; successor to the single discrete X register.
//  Holds NREGS registers of WIDTH bits each.
//  Supports clear, increment, decrement, data-bus load and multi-cycle shifts.
//  Sits between the data bus (din) and the address bus (abus); flags feed the ALU/flag unit.
// PARAMETERS
//  WIDTH  12  register width in bits (>=4)
//  NREGS  4   number of index registers (power of 2, >=2)
// PORTS
//  clk       in   1              clock; all state updates on the rising edge
//  rst       in   1              asynchronous, active-high reset
//  op_valid  in   1              op request; accepted when op_valid && op_ready
//  op_ready  out  1              high when idle (no shift in progress)
//  op        in   3              0 NOP, 1 CLR, 2 INC, 3 DEC, 4 LOAD, 5 SHL, 6 SHR, 7 SWAP
//  sel       in   $clog2(NREGS)  target register
//  din       in   WIDTH          LOAD value; SHL/SHR use din[$clog2(WIDTH)-1:0] as shift count
//  rd_en     in   1              drive the selected register onto abus this cycle
//  rd_sel    in   $clog2(NREGS)  register driven onto abus
//  abus      out  WIDTH          registered read data; 0 when not reading
//  abus_oe   out  1              registered; high the cycle after rd_en
//  zero      out  1              target register == 0 after the last completed op
//  carry     out  1              INC wrap-out / DEC borrow / last bit shifted out
// BEHAVIOUR
//  Reset values: all regs 0, abus 0, abus_oe 0, zero 1, carry 0, op_ready 1, FSM in IDLE.
//  Single-cycle ops (CLR/INC/DEC/LOAD/SWAP) complete one cycle after acceptance.
//   - INC: all-ones -> 0 with carry=1.
//   - DEC: 0 -> all-ones with carry=1.
//   - carry unchanged by CLR/LOAD/SWAP.
//   - SWAP exchanges reg[sel] with reg[sel^1].
//  FSM states: IDLE, SHIFT.
//   - SHL/SHR with count 0 completes like a single-cycle op; carry=0.
//   - Nonzero count: latch sel/dir/count, go to SHIFT, op_ready=0.
//   - In SHIFT: one bit per cycle, zero fill; carry = bit shifted out; count-1.
//   - Return to IDLE on the cycle count reaches 0; op_ready rises the next cycle.
//   - Counts >= WIDTH are legal: register ends 0; carry = last bit shifted out.
//  op_valid while op_ready=0 is ignored (no queueing); the requester must hold it.
//  zero updates together with each register write; during SHIFT it reflects the
//   shifting register.
//  Read path is 1-cycle latency: abus <= reg[rd_sel] when rd_en, else 0.
//   - Same-cycle read of a register being written returns the OLD value.
//  Reads are permitted during SHIFT.
//  rst asserted mid-shift aborts immediately; all state returns to reset values.
// CONFIGURATION
//  XREG_AUTOINC_EN defined:
//   - Adds input rd_inc (1 bit): when rd_en && rd_inc, reg[rd_sel] post-increments
//     (abus shows the pre-increment value).
//   - If it collides with an accepted op on the same register, the op wins and
//     rd_inc is dropped.
//   - rd_inc is blocked on the register being shifted.
//  XREG_AUTOINC_EN undefined: no rd_inc port; reads never modify registers.
// STRUCTURE
//  Package xreg_pkg: op enum (xreg_op_t), state enum (xreg_state_t), OP_* constants.
//  One sub-module, xreg_alu: combinational inc/dec/shift-by-1 with carry/zero outputs.
//  Instantiated once in xreg_bank.
//  Bank storage and FSM live in xreg_bank.
// TESTING (WIDTH=12, NREGS=4)
//  1. Reset mid-activity -> all regs 0, zero=1, op_ready=1, abus_oe=0.
//  2. LOAD r1=0xFFF, INC r1 -> r1=0x000, carry=1, zero=1; DEC r1 -> 0xFFF, carry=1.
//  3. LOAD r2=0x801, SHL count 3 -> op_ready low 3 cycles, r2=0x008, carry=0.
//     Also check mid-shift op_valid is ignored.
//  4. SHR count 13 on 0xFFF -> r=0, carry=1; SHL count 0 -> unchanged, carry=0,
//     single cycle.
//  5. LOAD r0 and read r0 in the same cycle -> abus shows the old value;
//     the next read shows the new value.
//  6. With XREG_AUTOINC_EN: r3=0x00A, rd_en+rd_inc x2 -> abus 0x00A then 0x00B,
//     r3=0x00C.

Source files
------------

// File: rtl/xreg_pkg.sv
// Shared types for the index-register bank.
//   xreg_op_t     : operation codes presented on the op port
//   xreg_state_t  : bank controller states
//   xreg_alu_fn_t : function select for the inc/dec/shift datapath
package xreg_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_CLR  = 3'd1,
        OP_INC  = 3'd2,
        OP_DEC  = 3'd3,
        OP_LOAD = 3'd4,
        OP_SHL  = 3'd5,
        OP_SHR  = 3'd6,
        OP_SWAP = 3'd7
    } xreg_op_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } xreg_state_t;

    typedef enum logic [1:0] {
        ALU_INC = 2'd0,
        ALU_DEC = 2'd1,
        ALU_SHL = 2'd2,
        ALU_SHR = 2'd3
    } xreg_alu_fn_t;

endpackage

// File: rtl/xreg_alu.sv
// Combinational datapath for one index register: +1, -1, shift-by-one.
// Ports:
//   a_i      : operand
//   fn_i     : function select (xreg_alu_fn_t)
//   res_c_o  : result
//   cout_c_o : INC wrap-out, DEC borrow, or the bit shifted out
//   zero_c_o : result == 0
module xreg_alu
    import xreg_pkg::*;
#(
    parameter int unsigned WIDTH = 12
) (
    input  logic [WIDTH-1:0] a_i,
    input  xreg_alu_fn_t     fn_i,
    output logic [WIDTH-1:0] res_c_o,
    output logic             cout_c_o,
    output logic             zero_c_o
);

    always_comb begin : p_alu
        res_c_o  = a_i;
        cout_c_o = 1'b0;
        case (fn_i)
            ALU_INC: {cout_c_o, res_c_o} = {1'b0, a_i} + (WIDTH+1)'(1);
            ALU_DEC: {cout_c_o, res_c_o} = {1'b0, a_i} - (WIDTH+1)'(1);
            ALU_SHL: {cout_c_o, res_c_o} = {a_i, 1'b0};
            ALU_SHR: {res_c_o, cout_c_o} = {1'b0, a_i};
            default: res_c_o = a_i;
        endcase
        zero_c_o = (res_c_o == '0);
    end

endmodule

// File: rtl/xreg_bank.sv
// Parametrised index-register bank (NREGS x WIDTH) with clear/inc/dec/load/
// swap and multi-cycle shifts, plus a registered read port onto the address bus.
// Optional feature macro: XREG_AUTOINC_EN adds rd_inc (post-increment on read).
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   op_valid/ready   : op handshake; ready is low while a shift is running
//   op, sel, din     : operation, target register, load value / shift count
//   rd_en, rd_sel    : read request; result on abus/abus_oe one cycle later
//   rd_inc           : (XREG_AUTOINC_EN only) post-increment the read register
//   abus, abus_oe    : registered read data and its enable
//   zero, carry      : flags of the last register write
module xreg_bank
    import xreg_pkg::*;
#(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned NREGS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic [2:0]               op,
    input  logic [$clog2(NREGS)-1:0] sel,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd_en,
    input  logic [$clog2(NREGS)-1:0] rd_sel,
`ifdef XREG_AUTOINC_EN
    input  logic                     rd_inc,
`endif
    output logic [WIDTH-1:0]         abus,
    output logic                     abus_oe,
    output logic                     zero,
    output logic                     carry
);

    localparam int unsigned SEL_W = $clog2(NREGS);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    xreg_state_t      state_q, state_d;
    logic [SEL_W-1:0] sh_sel_q, sh_sel_d;
    logic             sh_dir_q, sh_dir_d;
    logic [CNT_W-1:0] sh_cnt_q, sh_cnt_d;
    logic [CNT_W-1:0] sh_done_q, sh_done_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] abus_q, abus_d;
    logic             abus_oe_q, abus_oe_d;
    logic             ready_q;

    xreg_op_t         op_e;
    logic             accept;
    logic             shift_req;
    logic [CNT_W-1:0] cnt_in;
    logic             inc_en;

    logic [WIDTH-1:0] alu_a, alu_res;
    xreg_alu_fn_t     alu_fn;
    logic             alu_cout, alu_zero;

    assign op_e      = xreg_op_t'(op);
    assign accept    = op_valid && ready_q;
    assign shift_req = (op_e == OP_SHL) || (op_e == OP_SHR);
    assign cnt_in    = din[CNT_W-1:0];

    // Post-increment on read, suppressed when the register is owned by an op
`ifdef XREG_AUTOINC_EN
    logic inc_block;
    always_comb begin : p_inc_block
        inc_block = 1'b0;
        if (state_q == ST_SHIFT) begin
            inc_block = (rd_sel == sh_sel_q);
        end else if (accept && (op_e != OP_NOP)) begin
            inc_block = (rd_sel == sel) ||
                        ((op_e == OP_SWAP) && (rd_sel == (sel ^ SEL_W'(1))));
        end
    end
    assign inc_en = rd_en && rd_inc && !inc_block;
`else
    assign inc_en = 1'b0;
`endif

    // Shared ALU: shifting register while busy, else the op target
    always_comb begin : p_alu_sel
        alu_a  = regs_q[sel];
        alu_fn = (op_e == OP_DEC) ? ALU_DEC : ALU_INC;
        if (state_q == ST_SHIFT) begin
            alu_a  = regs_q[sh_sel_q];
            alu_fn = sh_dir_q ? ALU_SHR : ALU_SHL;
        end
    end

    xreg_alu #(.WIDTH(WIDTH)) u_alu (
        .a_i      (alu_a),
        .fn_i     (alu_fn),
        .res_c_o  (alu_res),
        .cout_c_o (alu_cout),
        .zero_c_o (alu_zero)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin : p_state_q
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin : p_state_d
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept && shift_req && (cnt_in != '0)) state_d = ST_SHIFT;
            ST_SHIFT: if (sh_cnt_q == CNT_W'(1)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath / flag next values
    always_comb begin : p_dp_d
        regs_d    = regs_q;
        sh_sel_d  = sh_sel_q;
        sh_dir_d  = sh_dir_q;
        sh_cnt_d  = sh_cnt_q;
        sh_done_d = sh_done_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        abus_d    = rd_en ? regs_q[rd_sel] : '0;
        abus_oe_d = rd_en;

        // Applied first so that any op write to the same register overrides it
        if (inc_en) regs_d[rd_sel] = regs_q[rd_sel] + WIDTH'(1);

        if (state_q == ST_SHIFT) begin
            regs_d[sh_sel_q] = alu_res;
            zero_d           = alu_zero;
            // Past WIDTH steps only fill bits leave; keep the last data bit out
            if (32'(sh_done_q) < WIDTH) carry_d = alu_cout;
            sh_cnt_d  = sh_cnt_q - CNT_W'(1);
            sh_done_d = sh_done_q + CNT_W'(1);
        end else if (accept) begin
            case (op_e)
                OP_CLR: begin
                    regs_d[sel] = '0;
                    zero_d      = 1'b1;
                end
                OP_INC, OP_DEC: begin
                    regs_d[sel] = alu_res;
                    zero_d      = alu_zero;
                    carry_d     = alu_cout;
                end
                OP_LOAD: begin
                    regs_d[sel] = din;
                    zero_d      = (din == '0);
                end
                OP_SHL, OP_SHR: begin
                    if (cnt_in == '0) begin
                        zero_d  = (regs_q[sel] == '0);
                        carry_d = 1'b0;
                    end else begin
                        sh_sel_d  = sel;
                        sh_dir_d  = (op_e == OP_SHR);
                        sh_cnt_d  = cnt_in;
                        sh_done_d = '0;
                    end
                end
                OP_SWAP: begin
                    regs_d[sel]               = regs_q[sel ^ SEL_W'(1)];
                    regs_d[sel ^ SEL_W'(1)]   = regs_q[sel];
                    zero_d                    = (regs_q[sel ^ SEL_W'(1)] == '0);
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin : p_dp_q
        if (rst) begin
            regs_q    <= '{default: '0};
            sh_sel_q  <= '0;
            sh_dir_q  <= 1'b0;
            sh_cnt_q  <= '0;
            sh_done_q <= '0;
            zero_q    <= 1'b1;
            carry_q   <= 1'b0;
            abus_q    <= '0;
            abus_oe_q <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            regs_q    <= regs_d;
            sh_sel_q  <= sh_sel_d;
            sh_dir_q  <= sh_dir_d;
            sh_cnt_q  <= sh_cnt_d;
            sh_done_q <= sh_done_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            abus_q    <= abus_d;
            abus_oe_q <= abus_oe_d;
            ready_q   <= (state_d == ST_IDLE);
        end
    end

    assign op_ready = ready_q;
    assign abus     = abus_q;
    assign abus_oe  = abus_oe_q;
    assign zero     = zero_q;
    assign carry    = carry_q;

endmodule

// File: tb/tb_xreg_bank.sv
// Self-checking bench for xreg_bank (WIDTH=12, NREGS=4): directed vectors,
// a behavioural model compared every cycle, and literal spot checks.
module tb_xreg_bank;
    import xreg_pkg::*;

    localparam int unsigned W    = 12;
    localparam int unsigned MASK = 32'hFFF;
`ifdef XREG_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [1:0]  sel = 2'd0;
    logic [11:0] din = 12'd0;
    logic        rd_en = 1'b0;
    logic [1:0]  rd_sel = 2'd0;
    logic        rd_inc_r = 1'b0;
    logic        op_ready, abus_oe, zero, carry;
    logic [11:0] abus;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    xreg_bank #(.WIDTH(12), .NREGS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op       (op),
        .sel      (sel),
        .din      (din),
        .rd_en    (rd_en),
        .rd_sel   (rd_sel),
`ifdef XREG_AUTOINC_EN
        .rd_inc   (rd_inc_r),
`endif
        .abus     (abus),
        .abus_oe  (abus_oe),
        .zero     (zero),
        .carry    (carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int unsigned m_reg [4];
    int unsigned m_abus = 0;
    bit          m_oe = 1'b0, m_zero = 1'b1, m_carry = 1'b0, m_ready = 1'b1;
    bit          sh_act = 1'b0, sh_right = 1'b0;
    int unsigned sh_reg = 0, sh_tot = 0, sh_k = 0, sh_orig = 0;
    int unsigned m_v = 0, m_cnt = 0;
    bit          m_blk = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            foreach (m_reg[i]) m_reg[i] = 0;
            m_abus = 0; m_oe = 0; m_zero = 1; m_carry = 0; m_ready = 1; sh_act = 0;
        end else begin
            m_blk  = 1'b0;
            m_abus = rd_en ? m_reg[rd_sel] : 0;
            m_oe   = rd_en;
            if (sh_act) begin
                m_blk = (32'(rd_sel) == sh_reg);
                sh_k++;
                m_v = sh_right ? (sh_orig >> sh_k) : ((sh_orig << sh_k) & MASK);
                m_reg[sh_reg] = m_v;
                m_zero = (m_v == 0);
                if (sh_k <= W)
                    m_carry = sh_right ? (((sh_orig >> (sh_k - 1)) & 1) != 0)
                                       : (((sh_orig >> (W - sh_k)) & 1) != 0);
                if (sh_k == sh_tot) begin sh_act = 0; m_ready = 1; end
            end else if (op_valid && m_ready) begin
                m_cnt = 32'(din) & 15;
                if (op != 3'd0) m_blk = 1'b1 && (rd_sel == sel);
                case (op)
                    3'd1: begin m_reg[sel] = 0; m_zero = 1; end
                    3'd2: begin
                        m_carry = (m_reg[sel] == MASK);
                        m_reg[sel] = (m_reg[sel] + 1) & MASK;
                        m_zero = (m_reg[sel] == 0);
                    end
                    3'd3: begin
                        m_carry = (m_reg[sel] == 0);
                        m_reg[sel] = (m_reg[sel] - 1) & MASK;
                        m_zero = (m_reg[sel] == 0);
                    end
                    3'd4: begin m_reg[sel] = 32'(din); m_zero = (din == 0); end
                    3'd5, 3'd6: begin
                        if (m_cnt == 0) begin
                            m_carry = 0; m_zero = (m_reg[sel] == 0);
                        end else begin
                            sh_act = 1; sh_right = (op == 3'd6); sh_reg = 32'(sel);
                            sh_tot = m_cnt; sh_k = 0; sh_orig = m_reg[sel]; m_ready = 0;
                        end
                    end
                    3'd7: begin
                        m_v = m_reg[sel];
                        m_reg[sel] = m_reg[sel ^ 2'd1];
                        m_reg[sel ^ 2'd1] = m_v;
                        m_zero = (m_reg[sel] == 0);
                        m_blk = m_blk || (rd_sel == (sel ^ 2'd1));
                    end
                    default: ;
                endcase
            end
            if (AUTOINC && rd_en && rd_inc_r && !m_blk)
                m_reg[rd_sel] = (m_reg[rd_sel] + 1) & MASK;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("abus",     32'(abus),     m_abus);
            check("abus_oe",  32'(abus_oe),  32'(m_oe));
            check("zero",     32'(zero),     32'(m_zero));
            check("carry",    32'(carry),    32'(m_carry));
            check("op_ready", 32'(op_ready), 32'(m_ready));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit v, input logic [2:0] o, input logic [1:0] s,
                         input logic [11:0] d, input bit re, input logic [1:0] rs,
                         input bit ri);
        op_valid = v; op = o; sel = s; din = d;
        rd_en = re; rd_sel = rs; rd_inc_r = ri;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        drive(1'b0, OP_NOP, 2'd0, 12'd0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic read_chk(input string nm, input logic [1:0] rs, input logic [11:0] exp);
        drive(1'b0, OP_NOP, 2'd0, 12'd0, 1'b1, rs, 1'b0);
        check(nm, 32'(abus), 32'(exp));
    endtask

    int cyc;

    initial begin
        #2 rst = 1'b1; chk_en = 1'b1;
        @(posedge clk); #1 rst = 1'b0;

        // 1: reset in the middle of a shift
        drive(1'b1, OP_LOAD, 2'd1, 12'h005, 1'b0, 2'd0, 1'b0);
        drive(1'b1, OP_SHL,  2'd1, 12'h005, 1'b0, 2'd0, 1'b0);
        check("t1_busy", 32'(op_ready), 0);
        drive(1'b0, OP_NOP, 2'd0, 12'd0, 1'b1, 2'd1, 1'b0);
        rst = 1'b1; #1;
        check("t1_rst_ready", 32'(op_ready), 1);
        check("t1_rst_zero",  32'(zero), 1);
        check("t1_rst_oe",    32'(abus_oe), 0);
        check("t1_rst_carry", 32'(carry), 0);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) read_chk($sformatf("t1_r%0d", i), 2'(i), 12'h000);

        // 2: INC wrap and DEC borrow
        drive(1'b1, OP_LOAD, 2'd1, 12'hFFF, 1'b0, 2'd0, 1'b0);
        check("t2_load_zero", 32'(zero), 0);
        drive(1'b1, OP_INC, 2'd1, 12'h000, 1'b0, 2'd0, 1'b0);
        check("t2_inc_carry", 32'(carry), 1);
        check("t2_inc_zero",  32'(zero), 1);
        read_chk("t2_inc_val", 2'd1, 12'h000);
        drive(1'b1, OP_DEC, 2'd1, 12'h000, 1'b0, 2'd0, 1'b0);
        check("t2_dec_carry", 32'(carry), 1);
        check("t2_dec_zero",  32'(zero), 0);
        read_chk("t2_dec_val", 2'd1, 12'hFFF);

        // 3: SHL by 3, requests during the shift are ignored
        drive(1'b1, OP_LOAD, 2'd2, 12'h801, 1'b0, 2'd0, 1'b0);
        check("t3_load_keeps_carry", 32'(carry), 1);
        drive(1'b1, OP_SHL, 2'd2, 12'h003, 1'b0, 2'd0, 1'b0);
        check("t3_ready_c0", 32'(op_ready), 0);
        drive(1'b1, OP_LOAD, 2'd2, 12'h555, 1'b0, 2'd0, 1'b0);
        check("t3_ready_c1", 32'(op_ready), 0);
        drive(1'b1, OP_LOAD, 2'd2, 12'h555, 1'b0, 2'd0, 1'b0);
        check("t3_ready_c2", 32'(op_ready), 0);
        drive(1'b1, OP_LOAD, 2'd2, 12'h555, 1'b0, 2'd0, 1'b0);
        check("t3_ready_c3", 32'(op_ready), 1);
        check("t3_carry", 32'(carry), 0);
        read_chk("t3_val", 2'd2, 12'h008);

        // 4: over-long SHR, then zero-count SHL
        drive(1'b1, OP_LOAD, 2'd3, 12'hFFF, 1'b0, 2'd0, 1'b0);
        drive(1'b1, OP_SHR,  2'd3, 12'h00D, 1'b0, 2'd0, 1'b0);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            if (op_ready) break;
            idle();
            cyc++;
        end
        check("t4_shr13_cycles", 32'(cyc), 13);
        check("t4_shr13_carry",  32'(carry), 1);
        check("t4_shr13_zero",   32'(zero), 1);
        read_chk("t4_shr13_val", 2'd3, 12'h000);
        drive(1'b1, OP_LOAD, 2'd3, 12'h5A5, 1'b0, 2'd0, 1'b0);
        check("t4_load_keeps_carry", 32'(carry), 1);
        drive(1'b1, OP_SHL, 2'd3, 12'h010, 1'b0, 2'd0, 1'b0);
        check("t4_shl0_ready", 32'(op_ready), 1);
        check("t4_shl0_carry", 32'(carry), 0);
        check("t4_shl0_zero",  32'(zero), 0);
        read_chk("t4_shl0_val", 2'd3, 12'h5A5);

        // 5: read-during-write returns the old value
        drive(1'b1, OP_LOAD, 2'd0, 12'h123, 1'b0, 2'd0, 1'b0);
        drive(1'b1, OP_LOAD, 2'd0, 12'h456, 1'b1, 2'd0, 1'b0);
        check("t5_old", 32'(abus), 32'h123);
        read_chk("t5_new", 2'd0, 12'h456);
        idle();
        check("t5_noread_abus", 32'(abus), 0);
        check("t5_noread_oe",   32'(abus_oe), 0);

        // SWAP, then CLR leaving carry untouched
        drive(1'b1, OP_SWAP, 2'd1, 12'h000, 1'b0, 2'd0, 1'b0);
        check("swap_zero", 32'(zero), 0);
        read_chk("swap_r0", 2'd0, 12'hFFF);
        read_chk("swap_r1", 2'd1, 12'h456);
        drive(1'b1, OP_INC, 2'd0, 12'h000, 1'b0, 2'd0, 1'b0);
        drive(1'b1, OP_CLR, 2'd1, 12'h000, 1'b0, 2'd0, 1'b0);
        check("clr_carry", 32'(carry), 1);
        check("clr_zero",  32'(zero), 1);
        read_chk("clr_r1", 2'd1, 12'h000);

`ifdef XREG_AUTOINC_EN
        // 6: post-increment reads and their blocking rules
        drive(1'b1, OP_LOAD, 2'd3, 12'h00A, 1'b0, 2'd0, 1'b0);
        drive(1'b0, OP_NOP, 2'd0, 12'h000, 1'b1, 2'd3, 1'b1);
        check("t6_rd1", 32'(abus), 32'h00A);
        drive(1'b0, OP_NOP, 2'd0, 12'h000, 1'b1, 2'd3, 1'b1);
        check("t6_rd2", 32'(abus), 32'h00B);
        read_chk("t6_final", 2'd3, 12'h00C);
        drive(1'b1, OP_LOAD, 2'd3, 12'h100, 1'b1, 2'd3, 1'b1);
        check("t6_collide_rd", 32'(abus), 32'h00C);
        read_chk("t6_collide_val", 2'd3, 12'h100);
        drive(1'b1, OP_LOAD, 2'd0, 12'h001, 1'b0, 2'd0, 1'b0);
        drive(1'b1, OP_SHL,  2'd0, 12'h002, 1'b0, 2'd0, 1'b0);
        drive(1'b0, OP_NOP,  2'd0, 12'h000, 1'b1, 2'd0, 1'b1);
        idle();
        read_chk("t6_shift_block", 2'd0, 12'h004);
`endif

        idle();
        idle();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
